// File: rtl/dht11_frame_filter.sv
// DHT11 frame filter: checksum check, DEPTH-sample moving average, stale detection and error counters.
// Optional over-temperature alarm is compiled in when DHT_TEMP_ALARM_EN is defined.
module dht11_frame_filter #(
    parameter int DEPTH        = 4,
    parameter int STALE_CYCLES = 150_000_000,
    parameter int TEMP_HI      = 35,
    parameter int TEMP_HYST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [39:0] frame_data,
    output logic [7:0]  hum_avg,
    output logic [7:0]  temp_avg,
    output logic        out_valid,
    output logic        stale,
    output logic [7:0]  crc_err_cnt,
    output logic [7:0]  drop_cnt,
    output logic        temp_alarm
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = 8 + AW;
    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    function automatic logic [7:0] frame_checksum(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

    state_t          state_r, state_s;
    logic [39:0]     frame_r;
    logic [7:0]      hum_buf_r  [DEPTH];
    logic [7:0]      temp_buf_r [DEPTH];
    logic [SW-1:0]   hum_sum_r, temp_sum_r;
    logic [SW-1:0]   hum_sum_s, temp_sum_s;
    logic [AW-1:0]   wp_r;
    logic            primed_r;
    logic [CW-1:0]   stale_cnt_r, stale_cnt_s;
    logic            stale_r;
    logic [7:0]      hum_avg_r, temp_avg_r;
    logic            out_valid_r;
    logic [7:0]      crc_err_cnt_r, drop_cnt_r;
    logic            latch_s, crc_fail_s, update_s, drop_s;
    logic [7:0]      hum_smp_s, temp_smp_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_s    = state_r;
        latch_s    = 1'b0;
        crc_fail_s = 1'b0;
        update_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_s = ST_CHECK;
                    latch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (frame_checksum(frame_r) == frame_r[7:0]) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s    = ST_IDLE;
                    crc_fail_s = 1'b1;
                end
            end
            ST_UPDATE: begin
                state_s  = ST_IDLE;
                update_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        drop_s = frame_valid && (state_r != ST_IDLE);
    end

    // Next running sums: first good frame fills the whole window with its sample
    always_comb begin
        hum_smp_s  = frame_r[39:32];
        temp_smp_s = frame_r[23:16];
        if (primed_r) begin
            hum_sum_s  = hum_sum_r  - {{AW{1'b0}}, hum_buf_r[wp_r]}  + {{AW{1'b0}}, hum_smp_s};
            temp_sum_s = temp_sum_r - {{AW{1'b0}}, temp_buf_r[wp_r]} + {{AW{1'b0}}, temp_smp_s};
        end else begin
            hum_sum_s  = {hum_smp_s,  {AW{1'b0}}};
            temp_sum_s = {temp_smp_s, {AW{1'b0}}};
        end
    end

    // Stale counter: measures cycles since the last UPDATE cycle, which counts as zero
    always_comb begin
        if (stale_cnt_r >= STALE_MAX) begin
            stale_cnt_s = stale_cnt_r;
        end else begin
            stale_cnt_s = stale_cnt_r + CW'(1);
        end
    end

    // Datapath: frame latch, averaging window, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r       <= 40'd0;
            hum_sum_r     <= '0;
            temp_sum_r    <= '0;
            wp_r          <= '0;
            primed_r      <= 1'b0;
            hum_avg_r     <= 8'd0;
            temp_avg_r    <= 8'd0;
            out_valid_r   <= 1'b0;
            crc_err_cnt_r <= 8'd0;
            drop_cnt_r    <= 8'd0;
            stale_cnt_r   <= STALE_MAX;
            stale_r       <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                hum_buf_r[i]  <= 8'd0;
                temp_buf_r[i] <= 8'd0;
            end
        end else begin
            out_valid_r <= update_s;
            if (latch_s) begin
                frame_r <= frame_data;
            end
            if (crc_fail_s && (crc_err_cnt_r != 8'd255)) begin
                crc_err_cnt_r <= crc_err_cnt_r + 8'd1;
            end
            if (drop_s && (drop_cnt_r != 8'd255)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
            if (update_s) begin
                hum_sum_r   <= hum_sum_s;
                temp_sum_r  <= temp_sum_s;
                hum_avg_r   <= hum_sum_s[SW-1:AW];
                temp_avg_r  <= temp_sum_s[SW-1:AW];
                primed_r    <= 1'b1;
                stale_cnt_r <= CW'(1);
                stale_r     <= 1'b0;
                if (primed_r) begin
                    hum_buf_r[wp_r]  <= hum_smp_s;
                    temp_buf_r[wp_r] <= temp_smp_s;
                    wp_r             <= wp_r + AW'(1);
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        hum_buf_r[i]  <= hum_smp_s;
                        temp_buf_r[i] <= temp_smp_s;
                    end
                end
            end else begin
                stale_cnt_r <= stale_cnt_s;
                stale_r     <= (stale_cnt_s >= STALE_MAX);
            end
        end
    end

`ifdef DHT_TEMP_ALARM_EN
    localparam logic [7:0] ALARM_SET = 8'(TEMP_HI);
    localparam logic [7:0] ALARM_CLR = 8'(TEMP_HI - TEMP_HYST);
    logic temp_alarm_r;

    // Hysteresis alarm, evaluated on the new average so it is valid alongside out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_alarm_r <= 1'b0;
        end else if (update_s) begin
            if (temp_sum_s[SW-1:AW] > ALARM_SET) begin
                temp_alarm_r <= 1'b1;
            end else if (temp_sum_s[SW-1:AW] <= ALARM_CLR) begin
                temp_alarm_r <= 1'b0;
            end
        end
    end

    assign temp_alarm = temp_alarm_r;
`else
    assign temp_alarm = 1'b0;
`endif

    assign hum_avg     = hum_avg_r;
    assign temp_avg    = temp_avg_r;
    assign out_valid   = out_valid_r;
    assign stale       = stale_r;
    assign crc_err_cnt = crc_err_cnt_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_dht11_frame_filter.sv
// Directed self-checking bench for dht11_frame_filter (DEPTH=4, STALE_CYCLES=100).
// Alarm scenario is exercised when DHT_TEMP_ALARM_EN is defined.
module tb_dht11_frame_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [39:0] frame_data;
    logic [7:0]  hum_avg, temp_avg, crc_err_cnt, drop_cnt;
    logic        out_valid, stale, temp_alarm;

    int errors = 0;
    int checks = 0;

    dht11_frame_filter #(
        .DEPTH(4), .STALE_CYCLES(100), .TEMP_HI(35), .TEMP_HYST(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
        .hum_avg(hum_avg), .temp_avg(temp_avg), .out_valid(out_valid), .stale(stale),
        .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt), .temp_alarm(temp_alarm)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one frame for a cycle, then wait (bounded) for out_valid; lat counts cycles after the strobe.
    task automatic send_wait(input logic [39:0] d, output int lat);
        frame_valid = 1'b1;
        frame_data  = d;
        tick();
        frame_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; frame_valid = 1'b0; frame_data = 40'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (hum_avg !== 8'd0)     begin errors++; $display("FAIL reset_hum: got %0d expected 0", hum_avg); end
        checks++; if (temp_avg !== 8'd0)    begin errors++; $display("FAIL reset_temp: got %0d expected 0", temp_avg); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (stale !== 1'b1)       begin errors++; $display("FAIL reset_stale: got %b expected 1", stale); end
        checks++; if (crc_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_crc: got %0d expected 0", crc_err_cnt); end
        checks++; if (drop_cnt !== 8'd0)    begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        checks++; if (temp_alarm !== 1'b0)  begin errors++; $display("FAIL reset_alarm: got %b expected 0", temp_alarm); end
    endtask

    task automatic test_good_frame;
        int lat;
        send_wait(40'h2D00190046, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL good_latency: got %0d expected 3", lat); end
        checks++; if (hum_avg !== 8'd45)   begin errors++; $display("FAIL good_hum: got %0d expected 45", hum_avg); end
        checks++; if (temp_avg !== 8'd25)  begin errors++; $display("FAIL good_temp: got %0d expected 25", temp_avg); end
        checks++; if (stale !== 1'b0)      begin errors++; $display("FAIL good_stale: got %b expected 0", stale); end
        tick();
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL good_strobe_width: got %b expected 0", out_valid); end
    endtask

    task automatic test_bad_crc;
        int pulses = 0;
        frame_valid = 1'b1; frame_data = 40'h2D00190047;
        tick();
        frame_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0)          begin errors++; $display("FAIL crc_no_valid: got %0d pulses expected 0", pulses); end
        checks++; if (crc_err_cnt !== 8'd1)  begin errors++; $display("FAIL crc_count: got %0d expected 1", crc_err_cnt); end
        checks++; if (hum_avg !== 8'd45)     begin errors++; $display("FAIL crc_hum: got %0d expected 45", hum_avg); end
        checks++; if (temp_avg !== 8'd25)    begin errors++; $display("FAIL crc_temp: got %0d expected 25", temp_avg); end
    endtask

    task automatic test_average;
        int lat;
        send_wait(40'h2D001D004A, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL avg1_latency: got %0d expected 3", lat); end
        checks++; if (temp_avg !== 8'd26)  begin errors++; $display("FAIL avg1_temp: got %0d expected 26", temp_avg); end
        checks++; if (hum_avg !== 8'd45)   begin errors++; $display("FAIL avg1_hum: got %0d expected 45", hum_avg); end
        // Nonzero decimal bytes: counted in the checksum only
        send_wait(40'h31051D0356, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL avg2_latency: got %0d expected 3", lat); end
        checks++; if (hum_avg !== 8'd46)   begin errors++; $display("FAIL avg2_hum: got %0d expected 46", hum_avg); end
        checks++; if (temp_avg !== 8'd27)  begin errors++; $display("FAIL avg2_temp: got %0d expected 27", temp_avg); end
    endtask

    task automatic test_drop;
        int lat;
        int extra = 0;
        frame_valid = 1'b1; frame_data = 40'h2D00190046;
        tick();
        frame_data = 40'h50003C008C;
        tick();
        frame_valid = 1'b0;
        lat = 2;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 3)           begin errors++; $display("FAIL drop_latency: got %0d expected 3", lat); end
        checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_cnt); end
        checks++; if (hum_avg !== 8'd46)   begin errors++; $display("FAIL drop_hum: got %0d expected 46", hum_avg); end
        checks++; if (temp_avg !== 8'd27)  begin errors++; $display("FAIL drop_temp: got %0d expected 27", temp_avg); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0)         begin errors++; $display("FAIL drop_ignored: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat;
        send_wait(40'h2D00190046, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL b2b_a_latency: got %0d expected 3", lat); end
        checks++; if (temp_avg !== 8'd27)  begin errors++; $display("FAIL b2b_a_temp: got %0d expected 27", temp_avg); end
        send_wait(40'h3C0023005F, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL b2b_b_latency: got %0d expected 3", lat); end
        checks++; if (hum_avg !== 8'd49)   begin errors++; $display("FAIL b2b_b_hum: got %0d expected 49", hum_avg); end
        checks++; if (temp_avg !== 8'd28)  begin errors++; $display("FAIL b2b_b_temp: got %0d expected 28", temp_avg); end
        checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL b2b_drop: got %0d expected 1", drop_cnt); end
    endtask

    task automatic test_stale;
        int lat;
        int n = 0;
        send_wait(40'h2D00190046, lat);
        checks++; if (hum_avg !== 8'd48)   begin errors++; $display("FAIL stale_hum: got %0d expected 48", hum_avg); end
        checks++; if (stale !== 1'b0)      begin errors++; $display("FAIL stale_fresh: got %b expected 0", stale); end
        while (stale !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n !== 99)            begin errors++; $display("FAIL stale_timing: got %0d cycles after out_valid expected 99", n); end
        tick(); tick();
        checks++; if (stale !== 1'b1)      begin errors++; $display("FAIL stale_hold: got %b expected 1", stale); end
        send_wait(40'h2D00190046, lat);
        checks++; if (lat !== 3)           begin errors++; $display("FAIL stale_clr_latency: got %0d expected 3", lat); end
        checks++; if (stale !== 1'b0)      begin errors++; $display("FAIL stale_clear: got %b expected 0", stale); end
        checks++; if (temp_avg !== 8'd27)  begin errors++; $display("FAIL stale_temp: got %0d expected 27", temp_avg); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses = 0;
        frame_valid = 1'b1; frame_data = 40'h50003C008C;
        tick();
        frame_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0)          begin errors++; $display("FAIL rmid_no_valid: got %0d expected 0", pulses); end
        checks++; if (hum_avg !== 8'd0)      begin errors++; $display("FAIL rmid_hum: got %0d expected 0", hum_avg); end
        checks++; if (stale !== 1'b1)        begin errors++; $display("FAIL rmid_stale: got %b expected 1", stale); end
        checks++; if (crc_err_cnt !== 8'd0)  begin errors++; $display("FAIL rmid_crc: got %0d expected 0", crc_err_cnt); end
        checks++; if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL rmid_drop: got %0d expected 0", drop_cnt); end
        send_wait(40'h3C0023005F, lat);
        checks++; if (hum_avg !== 8'd60)     begin errors++; $display("FAIL rmid_preload_hum: got %0d expected 60", hum_avg); end
        checks++; if (temp_avg !== 8'd35)    begin errors++; $display("FAIL rmid_preload_temp: got %0d expected 35", temp_avg); end
    endtask

    task automatic test_saturation;
        int pulses = 0;
        tick();
        frame_valid = 1'b1; frame_data = 40'h2D00190047;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        frame_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (crc_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_crc: got %0d expected 255", crc_err_cnt); end
        checks++; if (drop_cnt !== 8'd255)    begin errors++; $display("FAIL sat_drop: got %0d expected 255", drop_cnt); end
        checks++; if (pulses !== 0)           begin errors++; $display("FAIL sat_no_valid: got %0d expected 0", pulses); end
        checks++; if (temp_avg !== 8'd35)     begin errors++; $display("FAIL sat_temp: got %0d expected 35", temp_avg); end
    endtask

    task automatic test_alarm;
        int lat;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_wait(40'h280024004C, lat);
        checks++; if (temp_avg !== 8'd36)    begin errors++; $display("FAIL alarm_avg36: got %0d expected 36", temp_avg); end
`ifdef DHT_TEMP_ALARM_EN
        checks++; if (temp_alarm !== 1'b1)   begin errors++; $display("FAIL alarm_set: got %b expected 1", temp_alarm); end
        send_wait(40'h28001C0044, lat);
        checks++; if (temp_avg !== 8'd34)    begin errors++; $display("FAIL alarm_avg34: got %0d expected 34", temp_avg); end
        checks++; if (temp_alarm !== 1'b1)   begin errors++; $display("FAIL alarm_hold: got %b expected 1", temp_alarm); end
        send_wait(40'h2800200048, lat);
        checks++; if (temp_avg !== 8'd33)    begin errors++; $display("FAIL alarm_avg33: got %0d expected 33", temp_avg); end
        checks++; if (temp_alarm !== 1'b0)   begin errors++; $display("FAIL alarm_clear: got %b expected 0", temp_alarm); end
`else
        checks++; if (temp_alarm !== 1'b0)   begin errors++; $display("FAIL alarm_tied: got %b expected 0", temp_alarm); end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_average();
        test_drop();
        test_back_to_back();
        test_stale();
        test_reset_mid();
        test_saturation();
        test_alarm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
